// File: rtl/mmio_uart_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_regs_pkg
// Description : Shared MMIO select encodings and addresses used by the
//               controller decode and the MMIO/UART register block.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_uart_regs_pkg;

  // Access select produced by the controller's MMIO address decode.
  // Code 6 is unused and behaves like SEL_NONE.
  typedef enum logic [2:0] {
    SEL_CTRL = 3'd0,
    SEL_RX   = 3'd1,
    SEL_TX   = 3'd2,
    SEL_CC   = 3'd3,
    SEL_IC   = 3'd4,
    SEL_RST  = 3'd5,
    SEL_NONE = 3'd7
  } mmap_sel_e;

  // Memory map shared with the controller decode.
  localparam logic [31:0] C_ADDR_CTRL = 32'h8000_0000;
  localparam logic [31:0] C_ADDR_RX   = 32'h8000_0004;
  localparam logic [31:0] C_ADDR_TX   = 32'h8000_0008;
  localparam logic [31:0] C_ADDR_CC   = 32'h8000_0010;
  localparam logic [31:0] C_ADDR_IC   = 32'h8000_0014;
  localparam logic [31:0] C_ADDR_RST  = 32'h8000_0018;

  // Status word: bit0 = TX buffer free, bit1 = RX byte waiting.
  function automatic logic [31:0] f_ctrl_word(input logic rx_full, input logic tx_pending);
    return {30'b0, rx_full, ~tx_pending};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_regs_counter.sv
`default_nettype none
// ============================================================================
// Module      : mmio_counter
// Description : Free-running wrap-around counter with enable and a
//               synchronous clear that takes priority over the enable.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Clear beats increment; natural overflow provides the wrap to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/mmio_uart_regs.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_regs
// Description : MMIO register block: one-byte UART RX/TX buffers behind
//               ready/valid handshakes, cycle and retired-instruction
//               counters, and registered load data for write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_regs
  import mmio_uart_regs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mmap_sel,
  input  logic [31:0] mmap_wr_data,
  input  logic        inst_retire,
  output logic [31:0] mmap_rd_data,
  input  logic [7:0]  data_out,
  input  logic        data_out_valid,
  output logic        data_out_ready,
  output logic [7:0]  data_in,
  output logic        data_in_valid,
  input  logic        data_in_ready
);

  logic             r_rx_full;
  logic             r_rx_ready;
  logic [7:0]       r_rx_data;
  logic             r_tx_pending;
  logic [7:0]       r_tx_data;
  logic [31:0]      r_rd_data;

  logic             w_rx_capture;
  logic             w_rx_read;
  logic             w_tx_hs;
  logic             w_tx_accept;
  logic             w_cnt_clr;
  logic [CNT_W-1:0] w_cycle_cnt;
  logic [CNT_W-1:0] w_inst_cnt;
  logic             w_unused_wr;

  assign w_rx_capture = ~r_rx_full & data_out_valid;
  assign w_rx_read    = (mmap_sel == SEL_RX);
  assign w_tx_hs      = r_tx_pending & data_in_ready;
  assign w_tx_accept  = (mmap_sel == SEL_TX) & (~r_tx_pending | w_tx_hs);
  assign w_cnt_clr    = (mmap_sel == SEL_RST);
  assign w_unused_wr  = ^mmap_wr_data[31:8];

  mmio_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (1'b1),
    .i_clr   (w_cnt_clr),
    .o_count (w_cycle_cnt)
  );

  mmio_counter #(.CNT_W(CNT_W)) u_inst_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (inst_retire),
    .i_clr   (w_cnt_clr),
    .o_count (w_inst_cnt)
  );

  // RX buffer: capture only into an empty slot, a read frees a full slot;
  // the ready flag is kept as its own register so it has no logic in front.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_full  <= 1'b0;
      r_rx_ready <= 1'b1;
      r_rx_data  <= 8'h00;
    end else if (w_rx_capture) begin
      r_rx_full  <= 1'b1;
      r_rx_ready <= 1'b0;
      r_rx_data  <= data_out;
    end else if (w_rx_read) begin
      r_rx_full  <= 1'b0;
      r_rx_ready <= 1'b1;
    end
  end

  // TX buffer: a new write outranks the handshake clear so back-to-back
  // bytes keep valid asserted without a gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_pending <= 1'b0;
      r_tx_data    <= 8'h00;
    end else if (w_tx_accept) begin
      r_tx_pending <= 1'b1;
      r_tx_data    <= mmap_wr_data[7:0];
    end else if (w_tx_hs) begin
      r_tx_pending <= 1'b0;
    end
  end

  // Load data: sampled from pre-edge state on read selects, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= 32'h0;
    end else begin
      case (mmap_sel)
        SEL_CTRL: r_rd_data <= f_ctrl_word(r_rx_full, r_tx_pending);
        SEL_RX:   r_rd_data <= {24'h0, r_rx_data};
        SEL_CC:   r_rd_data <= 32'(w_cycle_cnt);
        SEL_IC:   r_rd_data <= 32'(w_inst_cnt);
        default:  r_rd_data <= r_rd_data;
      endcase
    end
  end

  assign mmap_rd_data   = r_rd_data;
  assign data_out_ready = r_rx_ready;
  assign data_in        = r_tx_data;
  assign data_in_valid  = r_tx_pending;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_regs
// Description : Self-checking bench for mmio_uart_regs with directed steps
//               and a randomized phase against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_regs;

  logic        clk;
  logic        rst;
  logic [2:0]  mmap_sel;
  logic [31:0] mmap_wr_data;
  logic        inst_retire;
  logic [31:0] mmap_rd_data;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        data_out_ready;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic        data_in_ready;

  // Narrow-counter instance, used to observe the wrap without 2^32 cycles.
  logic [31:0] rd4;
  logic        dor4;
  logic [7:0]  di4;
  logic        div4;

  int checks = 0;
  int errors = 0;

  // Reference model state (what software would observe).
  logic        m_rx_full;
  logic [7:0]  m_rx_byte;
  logic        m_tx_pend;
  logic [7:0]  m_tx_byte;
  int unsigned m_cc;
  int unsigned m_ic;
  logic [31:0] m_rd;
  logic [31:0] m_rd4;

  mmio_uart_regs dut (
    .clk(clk), .rst(rst), .mmap_sel(mmap_sel), .mmap_wr_data(mmap_wr_data),
    .inst_retire(inst_retire), .mmap_rd_data(mmap_rd_data),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready)
  );

  mmio_uart_regs #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mmap_sel(mmap_sel), .mmap_wr_data(mmap_wr_data),
    .inst_retire(inst_retire), .mmap_rd_data(rd4),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(dor4),
    .data_in(di4), .data_in_valid(div4), .data_in_ready(data_in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("rd_data", mmap_rd_data, m_rd);
    chk("rd_data_w4", rd4, m_rd4);
    chk("rx_ready", {31'b0, data_out_ready}, {31'b0, ~m_rx_full});
    chk("tx_valid", {31'b0, data_in_valid}, {31'b0, m_tx_pend});
    chk("tx_data", {24'b0, data_in}, {24'b0, m_tx_byte});
  endtask

  task automatic model_clear();
    m_rx_full = 0; m_rx_byte = 0; m_tx_pend = 0; m_tx_byte = 0;
    m_cc = 0; m_ic = 0; m_rd = 0; m_rd4 = 0;
  endtask

  // Asynchronous reset raised mid-cycle; outputs must drop before any edge.
  task automatic apply_reset();
    mmap_sel = 3'd7; inst_retire = 0; data_out_valid = 0; data_in_ready = 0;
    rst = 1'b1;
    #1;
    model_clear();
    chk("reset_rd", mmap_rd_data, 32'h0);
    chk("reset_rx_ready", {31'b0, data_out_ready}, 32'h1);
    chk("reset_tx_valid", {31'b0, data_in_valid}, 32'h0);
    chk("reset_tx_data", {24'b0, data_in}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One instruction slot: drive, predict from the rules, clock, compare.
  task automatic cycle(input logic [2:0] sel, input logic [31:0] wr, input logic ret,
                       input logic [7:0] dout, input logic dv, input logic rdy);
    logic        handshake;
    logic        n_rx_full, n_tx_pend;
    logic [7:0]  n_rx_byte, n_tx_byte;
    int unsigned n_cc, n_ic;
    logic [31:0] n_rd, n_rd4;
    mmap_sel = sel; mmap_wr_data = wr; inst_retire = ret;
    data_out = dout; data_out_valid = dv; data_in_ready = rdy;

    n_rd = m_rd; n_rd4 = m_rd4;
    if (sel == 3'd0) begin
      n_rd = (m_rx_full ? 32'd2 : 32'd0) + (m_tx_pend ? 32'd0 : 32'd1); n_rd4 = n_rd;
    end else if (sel == 3'd1) begin
      n_rd = 32'(m_rx_byte); n_rd4 = n_rd;
    end else if (sel == 3'd3) begin
      n_rd = m_cc; n_rd4 = m_cc % 16;
    end else if (sel == 3'd4) begin
      n_rd = m_ic; n_rd4 = m_ic % 16;
    end

    n_rx_full = m_rx_full; n_rx_byte = m_rx_byte;
    if (!m_rx_full && dv) begin
      n_rx_full = 1; n_rx_byte = dout;
    end else if (sel == 3'd1) begin
      n_rx_full = 0;
    end

    handshake = m_tx_pend && rdy;
    n_tx_pend = handshake ? 1'b0 : m_tx_pend;
    n_tx_byte = m_tx_byte;
    if (sel == 3'd2 && (!m_tx_pend || handshake)) begin
      n_tx_pend = 1; n_tx_byte = wr[7:0];
    end

    if (sel == 3'd5) begin
      n_cc = 0; n_ic = 0;
    end else begin
      n_cc = m_cc + 1; n_ic = m_ic + (ret ? 1 : 0);
    end

    @(posedge clk); #1;
    m_rx_full = n_rx_full; m_rx_byte = n_rx_byte;
    m_tx_pend = n_tx_pend; m_tx_byte = n_tx_byte;
    m_cc = n_cc; m_ic = n_ic; m_rd = n_rd; m_rd4 = n_rd4;
    chk_model();
  endtask

  initial begin
    rst = 1'b1;
    mmap_sel = 3'd7; mmap_wr_data = 0; inst_retire = 0;
    data_out = 0; data_out_valid = 0; data_in_ready = 0;
    apply_reset();

    // Load up both buffers, then reset in the middle of the transfer.
    cycle(3'd2, 32'h0000_00AB, 1, 8'h00, 0, 0);
    cycle(3'd7, 32'h0, 1, 8'h5A, 1, 0);
    apply_reset();

    // Cycle counter after ten idle cycles, then status word.
    for (int i = 0; i < 10; i++) cycle(3'd7, 32'h0, 0, 8'h00, 0, 0);
    cycle(3'd3, 32'h0, 0, 8'h00, 0, 0);
    chk("cc_after_10", mmap_rd_data, 32'd10);
    cycle(3'd0, 32'h0, 0, 8'h00, 0, 0);
    chk("ctrl_after_reset", mmap_rd_data, 32'h1);

    // Retired-instruction counter and counter clear.
    for (int i = 0; i < 4; i++) cycle(3'd7, 32'h0, 1, 8'h00, 0, 0);
    cycle(3'd4, 32'h0, 0, 8'h00, 0, 0);
    chk("ic_after_4", mmap_rd_data, 32'd4);
    cycle(3'd5, 32'h0, 1, 8'h00, 0, 0);
    cycle(3'd3, 32'h0, 0, 8'h00, 0, 0);
    chk("cc_after_clear", mmap_rd_data, 32'd0);
    cycle(3'd4, 32'h0, 0, 8'h00, 0, 0);
    chk("ic_after_clear", mmap_rd_data, 32'd0);

    // RX byte through the buffer.
    cycle(3'd7, 32'h0, 0, 8'h41, 1, 0);
    chk("rx_ready_low", {31'b0, data_out_ready}, 32'h0);
    cycle(3'd0, 32'h0, 0, 8'h00, 0, 0);
    chk("ctrl_rx_full", mmap_rd_data, 32'h3);
    cycle(3'd1, 32'h0, 0, 8'h00, 0, 0);
    chk("rx_read", mmap_rd_data, 32'h41);
    chk("rx_ready_back", {31'b0, data_out_ready}, 32'h1);

    // TX hold, dropped second write, handshake.
    cycle(3'd2, 32'h1234_5655, 0, 8'h00, 0, 0);
    chk("tx_data_55", {24'b0, data_in}, 32'h55);
    cycle(3'd7, 32'h0, 0, 8'h00, 0, 0);
    cycle(3'd2, 32'h0000_0066, 0, 8'h00, 0, 0);
    chk("tx_drop", {24'b0, data_in}, 32'h55);
    chk("tx_held", {31'b0, data_in_valid}, 32'h1);
    cycle(3'd7, 32'h0, 0, 8'h00, 0, 1);
    chk("tx_cleared", {31'b0, data_in_valid}, 32'h0);
    cycle(3'd0, 32'h0, 0, 8'h00, 0, 0);
    chk("ctrl_tx_free", mmap_rd_data, 32'h1);

    // Write on the handshake cycle keeps valid continuously high.
    cycle(3'd2, 32'h0000_0077, 0, 8'h00, 0, 0);
    cycle(3'd2, 32'h0000_0088, 0, 8'h00, 0, 1);
    chk("b2b_valid", {31'b0, data_in_valid}, 32'h1);
    chk("b2b_data", {24'b0, data_in}, 32'h88);
    cycle(3'd7, 32'h0, 0, 8'h00, 0, 1);

    // Counter wrap on the narrow instance: all-ones then zero.
    apply_reset();
    for (int i = 0; i < 15; i++) cycle(3'd7, 32'h0, 1, 8'h00, 0, 0);
    cycle(3'd3, 32'h0, 0, 8'h00, 0, 0);
    chk("wrap_max", rd4, 32'hF);
    cycle(3'd3, 32'h0, 0, 8'h00, 0, 0);
    chk("wrap_zero", rd4, 32'h0);
    cycle(3'd4, 32'h0, 0, 8'h00, 0, 0);
    chk("ic_max", rd4, 32'hF);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
            8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_uart_regs.md
# mmio_uart_regs

Memory-mapped I/O register block sitting directly downstream of the pipeline controller's MMIO address decode. It consumes the per-instruction MMIO select and store data from the execute stage and returns registered load data to the write-back mux one cycle later. It buffers one UART receive byte and one transmit byte behind ready/valid handshakes, and maintains the cycle and retired-instruction counters.

## Interface
- CNT_W, 32: width of the cycle and instruction counters.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mmap_sel  in  3  access select from execute stage: 0 CTRL read, 1 RX read, 2 TX write, 3 CC read, 4 IC read, 5 counter-reset write, 7 no access; 6 treated as 7.
- mmap_wr_data  in  32  store data; only [7:0] used, for TX.
- inst_retire  in  1  high for one cycle per retired non-bubble instruction.
- mmap_rd_data  out  32  registered load data to write-back mux.
- data_out  in  8  byte from UART receiver.
- data_out_valid  in  1  receiver byte valid.
- data_out_ready  out  1  block can accept a receive byte.
- data_in  out  8  byte to UART transmitter.
- data_in_valid  out  1  transmit byte valid.
- data_in_ready  in  1  transmitter accepts byte.

## Operation
- Each instruction occupies execute exactly one cycle; every cycle with mmap_sel in {0..5} is exactly one access.
- RX: rx_full flag plus 8-bit rx_data. data_out_ready = !rx_full. If !rx_full && data_out_valid: rx_data <= data_out, rx_full <= 1. RX read: mmap_rd_data <= {24'b0, rx_data}, rx_full <= 0. RX read while empty returns stale rx_data, no state change. Read while full with data_out_valid high: clear only; new byte captured the following cycle.
- TX: tx_pending flag plus tx_data; data_in_valid = tx_pending, data_in = tx_data. Handshake completes on tx_pending && data_in_ready -> tx_pending <= 0. TX write accepted when !tx_pending or handshake completes that same cycle: tx_data <= mmap_wr_data[7:0], tx_pending <= 1 (accept wins over clear). TX write while pending without handshake is dropped.
- CTRL read: {30'b0, rx_full, !tx_pending} (bit0 TX ready, bit1 RX valid), sampled before that edge's updates.
- cycle_cnt increments every cycle; inst_cnt increments when inst_retire. Both wrap at 2^CNT_W to 0.
- Counter-reset write (sel 5): both counters <= 0 that edge; clear beats increment.
- CC/IC read returns counter value before that edge's increment, zero-extended to 32 bits.
- mmap_rd_data updated only on read selects (0,1,3,4); holds otherwise.

## Timing
- Reset values: mmap_rd_data 0, data_out_ready 1, data_in_valid 0, data_in 0; rx_full 0, tx_pending 0, counters 0.
- Reset asserted mid-transfer discards buffered RX/TX bytes immediately (asynchronous).
- Load latency: access cycle N -> mmap_rd_data valid from cycle N+1, aligned with write-back.
- data_out_ready and data_in_valid are direct register outputs (no combinational path from mmap_sel).
- Earliest RX re-accept: one cycle after the RX read edge. TX back-to-back: a write on the handshake cycle keeps data_in_valid continuously high.

## Structure
- Shared package: mmap_sel encodings (CTRL, RX, TX, CC, IC, RST, NONE) and MMIO addresses 0x80000000, 0x80000004, 0x80000008, 0x80000010, 0x80000014, 0x80000018, common with the controller decode.
- One sub-module: mmio_counter (CNT_W-bit, enable + synchronous clear with priority, async reset), instantiated twice.

## Test plan
- Reset mid-operation -> all outputs at reset values; after release, CTRL read returns 0x00000001.
- data_out=0x41 with data_out_valid for 1 cycle -> data_out_ready falls next cycle; CTRL reads 0x3; RX read gives 0x00000041; data_out_ready high the cycle after.
- TX write 0x1234_5655 with data_in_ready low for 3 cycles -> data_in=0x55, data_in_valid held; second write 0x66 dropped; ready pulse clears valid; CTRL bit0=1.
- TX write on the same cycle as a completing handshake -> data_in_valid stays high, data_in changes to the new byte.
- 10 cycles after reset, CC read -> 10; inst_retire high 4 cycles, IC read -> 4; sel 5 with inst_retire high -> both counters 0 next cycle.
- Force cycle_cnt to 0xFFFFFFFF -> reads 0 on the following cycle.
